// File: rtl/parcel_align_ctrl.sv
// Instruction parcel aligner: turns a stream of 32-bit fetch words into one
// compressed, aligned 32-bit, or word-spanning instruction (or NOP) per cycle.
module parcel_align_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_fetch_addr,
  input  logic [31:0]     i_fetch_word,
  input  logic            i_fetch_valid,
  output logic            o_sel_nop,
  output logic            o_sel_spanning,
  output logic            o_sel_compressed,
  output logic [15:0]     o_raw_parcel,
  output logic [31:0]     o_spanning_instr,
  output logic [31:0]     o_effective_instr,
  output logic [XLEN-1:0] o_program_counter,
  output logic [XLEN-1:0] o_link_address
);

  typedef enum logic [1:0] {ST_A0, ST_H2F, ST_H2B, ST_SPAN} state_e;

  localparam logic [XLEN-1:0] RESET_PC_H = {RESET_PC[XLEN-1:1], 1'b0};
  localparam state_e          RESET_ST   = RESET_PC[1] ? ST_H2F : ST_A0;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [15:0]       buf_hi_q, buf_hi_d;
  logic [15:0]       saved_q, saved_d;

  logic [XLEN-1:0]   redir_pc;
  logic [XLEN-1:0]   pc_plus2;
  logic [XLEN-1:0]   pc_plus4;
  logic [15:0]       hi_half;
  logic              half_avail;
  logic              lo_comp;
  logic              hi_comp;
  logic              unused_redir_lsb;

  logic              emit_nop;
  logic              emit_span;
  logic              emit_comp;
  logic [15:0]       emit_parcel;
  logic [31:0]       emit_span_instr;
  logic [31:0]       emit_eff;
  logic [XLEN-1:0]   emit_pc;
  logic [XLEN-1:0]   emit_link;

  assign redir_pc         = {i_redirect_pc[XLEN-1:1], 1'b0};
  assign unused_redir_lsb = i_redirect_pc[0];
  assign pc_plus2         = pc_q + XLEN'(2);
  assign pc_plus4         = pc_q + XLEN'(4);
  // Only the upper half of a consumed word is ever needed later.
  assign hi_half          = (state_q == ST_H2B) ? buf_hi_q : i_fetch_word[31:16];
  assign half_avail       = (state_q == ST_H2B) || i_fetch_valid;
  assign lo_comp          = (i_fetch_word[1:0] != 2'b11);
  assign hi_comp          = (hi_half[1:0] != 2'b11);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RESET_ST;
      pc_q     <= RESET_PC_H;
      buf_hi_q <= '0;
      saved_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_hi_q <= buf_hi_d;
      saved_q  <= saved_d;
    end
  end

  // Next-state: redirect beats stall and flush; stall/flush consume nothing
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_hi_d = buf_hi_q;
    saved_d  = saved_q;
    if (i_redirect_valid) begin
      pc_d     = redir_pc;
      state_d  = redir_pc[1] ? ST_H2F : ST_A0;
      buf_hi_d = '0;
      saved_d  = '0;
    end else if (!i_stall && !i_flush) begin
      case (state_q)
        ST_A0: begin
          if (i_fetch_valid) begin
            if (lo_comp) begin
              pc_d     = pc_plus2;
              buf_hi_d = i_fetch_word[31:16];
              state_d  = ST_H2B;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        ST_H2F, ST_H2B: begin
          if (half_avail) begin
            if (hi_comp) begin
              pc_d    = pc_plus2;
              state_d = ST_A0;
            end else begin
              saved_d = hi_half;
              state_d = ST_SPAN;
            end
          end
        end
        ST_SPAN: begin
          if (i_fetch_valid) begin
            pc_d     = pc_plus4;
            buf_hi_d = i_fetch_word[31:16];
            state_d  = ST_H2B;
          end
        end
        default: state_d = ST_A0;
      endcase
    end
  end

  // Output decode: what this state would emit, plus the fetch address
  always_comb begin
    emit_nop        = 1'b1;
    emit_span       = 1'b0;
    emit_comp       = 1'b0;
    emit_parcel     = '0;
    emit_span_instr = '0;
    emit_eff        = '0;
    emit_pc         = pc_q;
    emit_link       = pc_plus4;
    o_fetch_addr    = {pc_q[XLEN-1:2], 2'b00};
    case (state_q)
      ST_A0: begin
        if (i_fetch_valid) begin
          emit_nop = 1'b0;
          if (lo_comp) begin
            emit_comp   = 1'b1;
            emit_parcel = i_fetch_word[15:0];
            emit_link   = pc_plus2;
          end else begin
            emit_eff = i_fetch_word;
          end
        end
      end
      ST_H2F, ST_H2B: begin
        if (half_avail && hi_comp) begin
          emit_nop    = 1'b0;
          emit_comp   = 1'b1;
          emit_parcel = hi_half;
          emit_link   = pc_plus2;
        end
      end
      ST_SPAN: begin
        o_fetch_addr = {pc_plus2[XLEN-1:2], 2'b00};
        if (i_fetch_valid) begin
          emit_nop        = 1'b0;
          emit_span       = 1'b1;
          emit_span_instr = {i_fetch_word[15:0], saved_q};
        end
      end
      default: emit_nop = 1'b1;
    endcase
  end

  // Output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sel_nop         <= 1'b1;
      o_sel_spanning    <= 1'b0;
      o_sel_compressed  <= 1'b0;
      o_raw_parcel      <= '0;
      o_spanning_instr  <= '0;
      o_effective_instr <= '0;
      o_program_counter <= '0;
      o_link_address    <= '0;
    end else if (i_redirect_valid) begin
      o_sel_nop        <= 1'b1;
      o_sel_spanning   <= 1'b0;
      o_sel_compressed <= 1'b0;
    end else if (!i_stall) begin
      o_sel_nop         <= emit_nop | i_flush;
      o_sel_spanning    <= emit_span & ~i_flush;
      o_sel_compressed  <= emit_comp & ~i_flush;
      o_raw_parcel      <= emit_parcel;
      o_spanning_instr  <= emit_span_instr;
      o_effective_instr <= emit_eff;
      o_program_counter <= emit_pc;
      o_link_address    <= emit_link;
    end
  end

endmodule

// File: tb/tb_parcel_align_ctrl.sv
// Directed bench for parcel_align_ctrl with a small word-addressed memory model.
module tb_parcel_align_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_stall;
  logic        i_flush;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic [31:0] fetch_addr;
  logic [31:0] i_fetch_word;
  logic        i_fetch_valid;
  logic        o_sel_nop;
  logic        o_sel_spanning;
  logic        o_sel_compressed;
  logic [15:0] o_raw_parcel;
  logic [31:0] o_spanning_instr;
  logic [31:0] o_effective_instr;
  logic [31:0] o_program_counter;
  logic [31:0] o_link_address;

  logic [31:0] mem [0:127];
  int tests = 0;
  int fails = 0;

  parcel_align_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_stall           (i_stall),
    .i_flush           (i_flush),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_pc     (i_redirect_pc),
    .o_fetch_addr      (fetch_addr),
    .i_fetch_word      (i_fetch_word),
    .i_fetch_valid     (i_fetch_valid),
    .o_sel_nop         (o_sel_nop),
    .o_sel_spanning    (o_sel_spanning),
    .o_sel_compressed  (o_sel_compressed),
    .o_raw_parcel      (o_raw_parcel),
    .o_spanning_instr  (o_spanning_instr),
    .o_effective_instr (o_effective_instr),
    .o_program_counter (o_program_counter),
    .o_link_address    (o_link_address)
  );

  always #5 i_clk = ~i_clk;

  assign i_fetch_word = mem[fetch_addr[8:2]];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_comp(input string tag, input logic [15:0] parcel,
                          input logic [31:0] pc, input logic [31:0] link);
    chk({tag, ".sel"}, 64'({o_sel_nop, o_sel_spanning, o_sel_compressed}), 64'(3'b001));
    chk({tag, ".parcel"}, 64'(o_raw_parcel), 64'(parcel));
    chk({tag, ".pc"}, 64'(o_program_counter), 64'(pc));
    chk({tag, ".link"}, 64'(o_link_address), 64'(link));
  endtask

  task automatic exp_align(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] link);
    chk({tag, ".sel"}, 64'({o_sel_nop, o_sel_spanning, o_sel_compressed}), 64'(3'b000));
    chk({tag, ".eff"}, 64'(o_effective_instr), 64'(instr));
    chk({tag, ".pc"}, 64'(o_program_counter), 64'(pc));
    chk({tag, ".link"}, 64'(o_link_address), 64'(link));
  endtask

  task automatic exp_span(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] link);
    chk({tag, ".sel"}, 64'({o_sel_nop, o_sel_spanning, o_sel_compressed}), 64'(3'b010));
    chk({tag, ".span"}, 64'(o_spanning_instr), 64'(instr));
    chk({tag, ".pc"}, 64'(o_program_counter), 64'(pc));
    chk({tag, ".link"}, 64'(o_link_address), 64'(link));
  endtask

  task automatic exp_nop(input string tag);
    chk({tag, ".sel"}, 64'({o_sel_nop, o_sel_spanning, o_sel_compressed}), 64'(3'b100));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_pc = '0; i_fetch_valid = 1'b1;

    // Reset state
    mem[0] = 32'h0010_0093;
    step();
    exp_nop("rst");
    chk("rst.pc", 64'(o_program_counter), 64'h0);
    chk("rst.link", 64'(o_link_address), 64'h0);
    chk("rst.eff", 64'(o_effective_instr), 64'h0);
    chk("rst.fa", 64'(fetch_addr), 64'h0);

    // Aligned 32-bit
    i_rst = 1'b0;
    step();
    exp_align("al", 32'h0010_0093, 32'h0, 32'h4);
    chk("al.fa", 64'(fetch_addr), 64'h4);

    // Compressed pair, second half without a fetch
    mem[0] = 32'h0005_0001;
    do_reset();
    step();
    exp_comp("cp0", 16'h0001, 32'h0, 32'h2);
    i_fetch_valid = 1'b0;
    step();
    exp_comp("cp1", 16'h0005, 32'h2, 32'h4);
    chk("cp1.fa", 64'(fetch_addr), 64'h4);
    i_fetch_valid = 1'b1;
    step();
    exp_align("cp2", 32'h0000_0013, 32'h4, 32'h8);

    // Spanning instruction
    mem[0] = 32'h0093_0001; mem[1] = 32'h0000_0010;
    do_reset();
    step();
    exp_comp("sp0", 16'h0001, 32'h0, 32'h2);
    step();
    exp_nop("sp1");
    chk("sp1.fa", 64'(fetch_addr), 64'h4);
    step();
    exp_span("sp2", 32'h0010_0093, 32'h2, 32'h6);
    step();
    exp_comp("sp3", 16'h0000, 32'h6, 32'h8);
    chk("sp3.fa", 64'(fetch_addr), 64'h8);

    // Redirect mid-span
    mem[8'h40] = 32'h0005_0013;
    do_reset();
    step();
    step();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0103;
    step();
    i_redirect_valid = 1'b0;
    exp_nop("rd0");
    chk("rd0.fa", 64'(fetch_addr), 64'h100);
    step();
    exp_comp("rd1", 16'h0005, 32'h102, 32'h104);

    // Reset mid-span discards the saved half
    do_reset();
    step();
    step();
    i_rst = 1'b1;
    step();
    exp_nop("rs0");
    i_rst = 1'b0;
    step();
    exp_comp("rs1", 16'h0001, 32'h0, 32'h2);

    // Stall after a compressed output, then fetch gaps
    mem[0] = 32'h0005_0001; mem[1] = 32'h0000_0013; mem[2] = 32'h0020_0113;
    do_reset();
    step();
    exp_comp("st0", 16'h0001, 32'h0, 32'h2);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_comp("st_hold", 16'h0001, 32'h0, 32'h2);
    end
    i_stall = 1'b0;
    step();
    exp_comp("st1", 16'h0005, 32'h2, 32'h4);
    i_fetch_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      exp_nop("gap");
      chk("gap.fa", 64'(fetch_addr), 64'h4);
    end
    i_fetch_valid = 1'b1;
    step();
    exp_align("st2", 32'h0000_0013, 32'h4, 32'h8);

    // Flush in A0 replays the same instruction
    i_flush = 1'b1;
    step();
    exp_nop("fl0");
    i_flush = 1'b0;
    step();
    exp_align("fl1", 32'h0020_0113, 32'h8, 32'hC);

    // PC wrap at the top of the address space
    mem[127] = 32'h0001_0013; mem[0] = 32'h0000_0013;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
    step();
    i_redirect_valid = 1'b0;
    exp_nop("wr0");
    chk("wr0.fa", 64'(fetch_addr), 64'hFFFF_FFFC);
    step();
    exp_comp("wr1", 16'h0001, 32'hFFFF_FFFE, 32'h0);
    chk("wr1.fa", 64'(fetch_addr), 64'h0);
    step();
    exp_align("wr2", 32'h0000_0013, 32'h0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
